// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one outstanding memory read at a time and buffers DEPTH fetched words.
// Optional: define FETCH_ALIGN_CHECK_EN to block issue of misaligned PCs and raise sticky alignError.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcValue,
  input  logic        pcValid,
  input  logic        flush,
  output logic        pcAdvance,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  input  logic        decodeReady,
  output logic        alignError
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSHWAIT
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc_mem_q    [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic addr_ok;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q;
  logic align_set;

  assign addr_ok   = (pcValue[1:0] == 2'b00);
  assign align_set = (state_q == IDLE) && pcValid && !addr_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      align_err_q <= 1'b0;
    end else if (align_set) begin
      align_err_q <= 1'b1;
    end
  end

  assign alignError = align_err_q;
`else
  assign addr_ok    = 1'b1;
  assign alignError = 1'b0;
`endif

  // FSM next-state; the queue slot is effectively reserved at issue because
  // count can only fall while a request is outstanding.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pcValid && !flush && addr_ok && (count_q < FULL)) begin
          issue   = 1'b1;
          addr_d  = pcValue;
          state_d = REQ;
        end
      end
      REQ: begin
        if (memAck) begin
          push    = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = FLUSHWAIT;
        end
      end
      FLUSHWAIT: begin
        if (memAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = (count_q != '0) && decodeReady && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= memData;
      pc_mem_q[wr_ptr_q]    <= addr_q;
    end
  end

  assign pcAdvance  = issue && !reset;
  assign memReq     = (state_q != IDLE);
  assign memAddr    = addr_q;
  assign instrValid = (count_q != '0);
  assign instr      = instr_mem_q[rd_ptr_q];
  assign instrPC    = pc_mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    push |-> (count_q < FULL));

endmodule
